// File: rtl/an_dec_pkg.sv
// rtl/an_dec_pkg.sv - shared constants, state encoding and width helper for the AN-code decoder
package an_dec_pkg;

    localparam int A_DEF  = 19;
    localparam int W_DEF  = 9;
    localparam int NW_DEF = 4;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_RES  = 3'd1,
        ST_SRCH = 3'd2,
        ST_DIV  = 3'd3,
        ST_DONE = 3'd4
    } state_e;

    function automatic int clog2(input int v);
        int r;
        r = 0;
        for (int i = 0; i < 32; i++) begin
            if ((1 << r) < v) r = r + 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/an_serial_div.sv
// rtl/an_serial_div.sv - W-cycle restoring divider by the constant A with start/busy/done
module an_serial_div
    import an_dec_pkg::*;
#(
    parameter int A = A_DEF,
    parameter int W = W_DEF
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic [W-1:0] dividend,
    output logic         busy,
    output logic         done,
    output logic [W-1:0] quot
);

    localparam int RW = clog2(A);
    localparam int CW = clog2(W + 1);
    localparam logic [RW:0]   A_X  = (RW + 1)'(A);
    localparam logic [CW-1:0] LAST = CW'(W - 1);

    logic [W-1:0]  dsh;
    logic [RW-1:0] rem;
    logic [CW-1:0] cnt;
    logic [RW:0]   trial;
    logic [RW:0]   trial_sub;
    logic          ge;

    assign trial     = {rem, dsh[W-1]};
    assign trial_sub = trial - A_X;
    assign ge        = (trial >= A_X);
    // done is combinational so the quotient register is final on the same edge the FSM leaves DIV
    assign done      = busy && (cnt == LAST);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            busy <= 1'b0;
            cnt  <= '0;
            dsh  <= '0;
            rem  <= '0;
            quot <= '0;
        end else if (start) begin
            busy <= 1'b1;
            cnt  <= '0;
            dsh  <= dividend;
            rem  <= '0;
            quot <= '0;
        end else if (busy) begin
            rem  <= ge ? trial_sub[RW-1:0] : trial[RW-1:0];
            quot <= {quot[W-2:0], ge};
            dsh  <= dsh << 1;
            cnt  <= cnt + 1'b1;
            if (done) busy <= 1'b0;
        end
    end

endmodule

// File: rtl/an_dec_seq.sv
// rtl/an_dec_seq.sv - sequential single-error-correcting AN decoder; optional AN_DEC_STATS_EN adds stat counters
module an_dec_seq
    import an_dec_pkg::*;
#(
    parameter int A  = A_DEF,
    parameter int W  = W_DEF,
    parameter int NW = NW_DEF
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [W-1:0]  in_code,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [NW-1:0] out_n,
    output logic          out_corr,
    output logic          out_uncorr,
    output logic          out_ovf
`ifdef AN_DEC_STATS_EN
    ,
    output logic [15:0]   stat_corr,
    output logic [15:0]   stat_uncorr
`endif
);

    localparam int RW = clog2(A);
    localparam int CW = clog2(W + 1);
    localparam logic [RW:0]   A_X  = (RW + 1)'(A);
    localparam logic [RW-1:0] A_R  = RW'(A);
    localparam logic [CW-1:0] LAST = CW'(W - 1);

    localparam logic [2:0] S_IDLE = ST_IDLE;
    localparam logic [2:0] S_RES  = ST_RES;
    localparam logic [2:0] S_SRCH = ST_SRCH;
    localparam logic [2:0] S_DIV  = ST_DIV;
    localparam logic [2:0] S_DONE = ST_DONE;

    logic [2:0]    state;
    logic [CW-1:0] cnt;
    logic [W-1:0]  code;
    logic [W-1:0]  sh;
    logic [W-1:0]  mask;
    logic [RW-1:0] r;
    logic [RW-1:0] p;
    logic          corr;
    logic          uncorr;

    logic [RW:0]   r_dbl, r_sub, p_dbl, p_sub;
    logic [RW-1:0] r_step, p_step;
    logic          r_nz, bitk, hit_sub, hit_add, hit;
    logic [W-1:0]  code_fix;
    logic          div_start, div_busy, div_done;
    logic [W-1:0]  quot;

    assign r_dbl  = {r, sh[W-1]};
    assign r_sub  = r_dbl - A_X;
    assign r_step = (r_dbl >= A_X) ? r_sub[RW-1:0] : r_dbl[RW-1:0];
    assign p_dbl  = {p, 1'b0};
    assign p_sub  = p_dbl - A_X;
    assign p_step = (p_dbl >= A_X) ? p_sub[RW-1:0] : p_dbl[RW-1:0];

    // polarity check keeps the corrected word inside W bits: only clear a 1 or set a 0
    assign r_nz     = |r;
    assign bitk     = |(code & mask);
    assign hit_sub  = (state == S_SRCH) && r_nz && !corr && (p == r) && bitk;
    assign hit_add  = (state == S_SRCH) && r_nz && !corr && ((A_R - p) == r) && !bitk;
    assign hit      = hit_sub || hit_add;
    assign code_fix = hit_sub ? (code - mask) : (hit_add ? (code + mask) : code);

    assign div_start = (state == S_SRCH) && (cnt == LAST);

    an_serial_div #(
        .A (A),
        .W (W)
    ) u_div (
        .clk      (clk),
        .rst      (rst),
        .start    (div_start),
        .dividend (code_fix),
        .busy     (div_busy),
        .done     (div_done),
        .quot     (quot)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state  <= S_IDLE;
            cnt    <= '0;
            code   <= '0;
            sh     <= '0;
            mask   <= '0;
            r      <= '0;
            p      <= '0;
            corr   <= 1'b0;
            uncorr <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (in_valid) begin
                        code   <= in_code;
                        sh     <= in_code;
                        mask   <= W'(1);
                        r      <= '0;
                        p      <= RW'(1);
                        corr   <= 1'b0;
                        uncorr <= 1'b0;
                        cnt    <= '0;
                        state  <= S_RES;
                    end
                end
                S_RES: begin
                    r  <= r_step;
                    sh <= sh << 1;
                    if (cnt == LAST) begin
                        cnt   <= '0;
                        state <= S_SRCH;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                S_SRCH: begin
                    if (hit) begin
                        code <= code_fix;
                        corr <= 1'b1;
                    end
                    p    <= p_step;
                    mask <= mask << 1;
                    if (cnt == LAST) begin
                        cnt    <= '0;
                        uncorr <= r_nz && !corr && !hit;
                        state  <= S_DIV;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                S_DIV: begin
                    if (div_done) state <= S_DONE;
                end
                S_DONE: begin
                    if (out_ready) state <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    assign in_ready   = (state == S_IDLE) && !div_busy;
    assign out_valid  = (state == S_DONE);
    assign out_n      = (out_valid && !uncorr) ? quot[NW-1:0] : '0;
    assign out_corr   = out_valid && corr;
    assign out_uncorr = out_valid && uncorr;
    assign out_ovf    = out_valid && (|quot[W-1:NW]);

`ifdef AN_DEC_STATS_EN
    logic hs_done;
    assign hs_done = out_valid && out_ready;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stat_corr   <= '0;
            stat_uncorr <= '0;
        end else if (hs_done) begin
            if (corr && (stat_corr != 16'hFFFF))
                stat_corr <= stat_corr + 16'd1;
            if (uncorr && (stat_uncorr != 16'hFFFF))
                stat_uncorr <= stat_uncorr + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_an_dec_seq.sv
// tb/tb_an_dec_seq.sv - randomized self-checking bench for an_dec_seq against an arithmetic reference model
module tb_an_dec_seq;

    localparam int A  = 19;
    localparam int W  = 9;
    localparam int NW = 4;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          in_valid = 1'b0;
    logic          out_ready = 1'b0;
    logic [W-1:0]  in_code = '0;
    logic          in_ready;
    logic          out_valid;
    logic [NW-1:0] out_n;
    logic          out_corr;
    logic          out_uncorr;
    logic          out_ovf;

    an_dec_seq #(.A(A), .W(W), .NW(NW)) dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_code    (in_code),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_n      (out_n),
        .out_corr   (out_corr),
        .out_uncorr (out_uncorr),
        .out_ovf    (out_ovf)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
        end
    endtask

    // decode straight from the code definition: residue, bit-flip search, integer division
    function automatic void model(input int c, output int n, output int corr,
                                  output int unc, output int ovf);
        int r, cc, q;
        r = c % A;
        cc = c;
        corr = 0;
        unc = 0;
        if (r != 0) begin
            for (int k = 0; k < W; k++) begin
                int pk, b;
                pk = (1 << k) % A;
                b = (c >> k) & 1;
                if (corr == 0 && pk == r && b == 1) begin
                    cc = c - (1 << k);
                    corr = 1;
                end else if (corr == 0 && (A - pk) == r && b == 0) begin
                    cc = c + (1 << k);
                    corr = 1;
                end
            end
            unc = (corr == 0) ? 1 : 0;
        end
        q = cc / A;
        ovf = (q >= (1 << NW)) ? 1 : 0;
        n = (unc != 0) ? 0 : (q % (1 << NW));
    endfunction

    // cycle-level expectation: 0 idle, 1 computing, 2 result held
    int m_st = 0;
    int m_cnt = 0;
    int e_n, e_corr, e_unc, e_ovf;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_st = 0;
        end else begin
            case (m_st)
                0: if (in_valid) begin
                    model(int'(in_code), e_n, e_corr, e_unc, e_ovf);
                    m_st = 1;
                    m_cnt = 0;
                end
                1: begin
                    m_cnt++;
                    if (m_cnt == 3 * W) m_st = 2;
                end
                default: if (out_ready) m_st = 0;
            endcase
        end
    end

    always @(negedge clk) begin
        if (!rst) begin
            chk("in_ready", int'(in_ready), (m_st == 0) ? 1 : 0);
            chk("out_valid", int'(out_valid), (m_st == 2) ? 1 : 0);
            if (m_st == 2) begin
                chk("out_n", int'(out_n), e_n);
                chk("out_corr", int'(out_corr), e_corr);
                chk("out_uncorr", int'(out_uncorr), e_unc);
                chk("out_ovf", int'(out_ovf), e_ovf);
            end
        end
    end

    task automatic send(input int c, input int hold, input bit lit,
                        input int xn, input int xc, input int xu, input int xo);
        int t;
        t = 0;
        while (!in_ready && t < 200) begin
            @(posedge clk); #1;
            t++;
        end
        chk("accept_wait", int'(in_ready), 1);
        in_valid = 1'b1;
        in_code = W'(c);
        @(posedge clk); #1;
        in_valid = 1'b0;
        t = 0;
        while (!out_valid && t < 200) begin
            @(posedge clk); #1;
            t++;
        end
        chk("latency", t, 3 * W);
        if (lit) begin
            chk("lit_n", int'(out_n), xn);
            chk("lit_corr", int'(out_corr), xc);
            chk("lit_uncorr", int'(out_uncorr), xu);
            chk("lit_ovf", int'(out_ovf), xo);
        end
        // offered words during backpressure must be ignored
        in_valid = (hold > 0);
        in_code = W'($urandom_range(0, (1 << W) - 1));
        repeat (hold) begin
            @(posedge clk); #1;
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        in_valid = 1'b0;
    endtask

    int tc[7] = '{209, 211, 208, 465, 193, 21, 304};
    int tn[7] = '{11, 11, 11, 11, 11, 0, 0};
    int tk[7] = '{0, 1, 1, 1, 1, 0, 0};
    int tu[7] = '{0, 0, 0, 0, 0, 1, 0};
    int to[7] = '{0, 0, 0, 0, 0, 0, 1};

    initial begin
        #5_000_000;
        $display("FAIL watchdog actual=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int mn, mc, mu, mo, c;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_in_ready", int'(in_ready), 1);
        chk("rst_out_valid", int'(out_valid), 0);
        chk("rst_out_n", int'(out_n), 0);
        chk("rst_flags", int'({out_corr, out_uncorr, out_ovf}), 0);
        rst = 1'b0;
        @(posedge clk); #1;

        for (int i = 0; i < 7; i++) begin
            model(tc[i], mn, mc, mu, mo);
            chk("model_n", mn, tn[i]);
            chk("model_corr", mc, tk[i]);
            chk("model_unc", mu, tu[i]);
            chk("model_ovf", mo, to[i]);
        end

        for (int i = 0; i < 7; i++)
            send(tc[i], 0, 1'b1, tn[i], tk[i], tu[i], to[i]);

        send(209, 10, 1'b1, 11, 0, 0, 0);

        in_valid = 1'b1;
        in_code = W'(209);
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (12) begin
            @(posedge clk); #1;
        end
        #2;
        rst = 1'b1;
        #1;
        chk("mid_rst_in_ready", int'(in_ready), 1);
        chk("mid_rst_out_valid", int'(out_valid), 0);
        chk("mid_rst_out_n", int'(out_n), 0);
        chk("mid_rst_flags", int'({out_corr, out_uncorr, out_ovf}), 0);
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        send(209, 0, 1'b1, 11, 0, 0, 0);

        for (int i = 0; i < 250; i++) begin
            if ($urandom_range(0, 1) == 0) begin
                c = $urandom_range(0, (1 << W) - 1);
            end else begin
                c = A * $urandom_range(0, ((1 << W) - 1) / A);
                if ($urandom_range(0, 3) != 0) c = c ^ (1 << $urandom_range(0, W - 1));
            end
            send(c, $urandom_range(0, 3), 1'b0, 0, 0, 0, 0);
            repeat ($urandom_range(0, 2)) begin
                @(posedge clk); #1;
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
